// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the self-initialising RAM block.
package ram_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int CW_DEF = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ram_sat_cnt.sv
// CW-bit up-counter that sticks at all-ones; clr_i is a synchronous clear with priority.
module ram_sat_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_resp.sv
// Single-port RAM that zero-fills itself after reset (INIT), then serves
// one access per cycle (RUN) with registered read data and access counters.
module ram_resp
    import ram_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          ready,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt,
    output logic          err
);

    localparam int DEPTH = 1 << AW;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          err_q, err_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wr_inc;
    logic          rd_inc;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        wr_inc    = 1'b0;
        rd_inc    = 1'b0;
        case (state_q)
            INIT: begin
                // ptr holds at the last location so it only returns to 0 via reset
                mem_we = 1'b1;
                if (wr) begin
                    err_d = 1'b1;
                end
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RUN: begin
                if (wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr;
                    mem_wdata = din;
                    wr_inc    = 1'b1;
                end else begin
                    dout_d = mem_q[addr];
                    rd_inc = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset of its own; the INIT sweep clears it after every reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    ram_sat_cnt #(.CW(CW)) u_wr_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (wr_inc),
        .cnt_o (wr_cnt)
    );

    ram_sat_cnt #(.CW(CW)) u_rd_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (rd_inc),
        .cnt_o (rd_cnt)
    );

    assign dout  = dout_q;
    assign ready = (state_q == RUN);
    assign err   = err_q;

endmodule

// File: tb/tb_ram_resp.sv
// Bench for ram_resp: a default instance plus a CW=4 instance sharing the same
// stimulus, checked against an edge-by-edge behavioural model of the RAM.
module tb_ram_resp;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CW  = 16;
    localparam int CWS = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr;
    logic [DW-1:0]  din;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dout, dout_s;
    logic           ready, ready_s;
    logic [CW-1:0]  wr_cnt, rd_cnt;
    logic [CWS-1:0] wr_cnt_s, rd_cnt_s;
    logic           err, err_s;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: edges spent clearing, unsaturated access totals, memory image.
    logic [DW-1:0] m_mem [16];
    int            m_init;
    int            m_wr;
    int            m_rd;
    logic          m_err;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] exp_q[$];

    ram_resp #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .addr(addr),
        .dout(dout), .ready(ready), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err(err)
    );

    ram_resp #(.DW(DW), .AW(AW), .CW(CWS)) dut_s (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .addr(addr),
        .dout(dout_s), .ready(ready_s), .wr_cnt(wr_cnt_s), .rd_cnt(rd_cnt_s), .err(err_s)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic [AW-1:0] a);
        wr   = w;
        din  = d;
        addr = a;
        @(posedge clk);
        if (rst) begin
            m_init = 0;
            m_wr   = 0;
            m_rd   = 0;
            m_err  = 1'b0;
            m_dout = '0;
        end else if (m_init < 16) begin
            if (w) m_err = 1'b1;
            m_mem[m_init] = '0;
            m_init++;
        end else if (w) begin
            m_mem[a] = d;
            m_wr++;
        end else begin
            m_dout = m_mem[a];
            m_rd++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, '0, '0);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            cycle(1'b0, '0, '0);
            n++;
        end
        checks++;
        if (ready !== 1'b1 || n != 16) begin
            $display("FAIL wait_ready ready=%b edges=%0d required ready=1 after 16", ready, n);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, 8'hFF, 4'h5);
        cycle(1'b1, 8'hFF, 4'h5);
        checks++;
        if (ready !== 1'b0 || dout !== 8'h00 || err !== 1'b0 || wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
            $display("FAIL reset_state ready=%b dout=%h err=%b wr_cnt=%0d rd_cnt=%0d required 0/00/0/0/0",
                     ready, dout, err, wr_cnt, rd_cnt);
            failures++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, '0, '0);
            checks++;
            if (ready !== (k == 16) || rd_cnt !== 16'd0 || dout !== 8'h00) begin
                $display("FAIL init_idle edge=%0d ready=%b rd_cnt=%0d dout=%h required ready=%b rd_cnt=0 dout=00",
                         k, ready, rd_cnt, dout, (k == 16));
                failures++;
            end
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, '0, '0);
            checks++;
            if (rd_cnt !== CW'(k) || dout !== 8'h00 || ready !== 1'b1) begin
                $display("FAIL run_idle read=%0d rd_cnt=%0d dout=%h ready=%b required rd_cnt=%0d dout=00 ready=1",
                         k, rd_cnt, dout, ready, k);
                failures++;
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        wait_ready();
        cycle(1'b1, 8'hA5, 4'd3);
        checks++;
        if (dout !== 8'h00 || wr_cnt !== 16'd1) begin
            $display("FAIL write_hold dout=%h wr_cnt=%0d required dout=00 wr_cnt=1", dout, wr_cnt);
            failures++;
        end
        cycle(1'b0, '0, 4'd3);
        checks++;
        if (dout !== 8'hA5 || wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
            $display("FAIL write_read dout=%h wr_cnt=%0d rd_cnt=%0d required A5/1/1", dout, wr_cnt, rd_cnt);
            failures++;
        end
    endtask

    task automatic test_fill_readback();
        logic [DW-1:0] e;
        do_reset();
        wait_ready();
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), AW'(i));
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back(DW'(i));
            cycle(1'b0, '0, AW'(i));
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                $display("FAIL readback addr=%0d dout=%h required %h", i, dout, e);
                failures++;
            end
        end
        checks++;
        if (wr_cnt !== 16'd16 || rd_cnt !== 16'd16) begin
            $display("FAIL fill_counts wr_cnt=%0d rd_cnt=%0d required 16/16", wr_cnt, rd_cnt);
            failures++;
        end
    endtask

    task automatic test_init_write();
        do_reset();
        for (int k = 1; k <= 4; k++) cycle(1'b0, '0, '0);
        cycle(1'b1, 8'hFF, 4'd9);
        checks++;
        if (err !== 1'b1 || ready !== 1'b0) begin
            $display("FAIL init_write_err err=%b ready=%b required err=1 ready=0", err, ready);
            failures++;
        end
        for (int k = 6; k <= 16; k++) cycle(1'b0, '0, '0);
        checks++;
        if (ready !== 1'b1 || err !== 1'b1) begin
            $display("FAIL init_write_ready ready=%b err=%b required 1/1", ready, err);
            failures++;
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, AW'(i));
            checks++;
            if (dout !== 8'h00 || err !== 1'b1) begin
                $display("FAIL init_write_read addr=%0d dout=%h err=%b required 00/1", i, dout, err);
                failures++;
            end
        end
        checks++;
        if (wr_cnt !== 16'd0 || rd_cnt !== 16'd16) begin
            $display("FAIL init_write_counts wr_cnt=%0d rd_cnt=%0d required 0/16", wr_cnt, rd_cnt);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_ready();
        cycle(1'b1, 8'h3C, 4'd7);
        rst = 1'b1;
        cycle(1'b1, 8'h77, 4'd7);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || err !== 1'b0 || wr_cnt !== 16'd0) begin
            $display("FAIL mid_reset ready=%b err=%b wr_cnt=%0d required 0/0/0", ready, err, wr_cnt);
            failures++;
        end
        wait_ready();
        cycle(1'b0, '0, 4'd7);
        checks++;
        if (dout !== 8'h00 || wr_cnt !== 16'd0 || rd_cnt !== 16'd1 || err !== 1'b0) begin
            $display("FAIL mid_reset_read dout=%h wr_cnt=%0d rd_cnt=%0d err=%b required 00/0/1/0",
                     dout, wr_cnt, rd_cnt, err);
            failures++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        wait_ready();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, '0, AW'($urandom_range(0, 15)));
            checks++;
            if (rd_cnt_s !== CWS'(sat(i, 15)) || rd_cnt !== CW'(i)) begin
                $display("FAIL saturation read=%0d rd_cnt_cw4=%0d rd_cnt=%0d required %0d/%0d",
                         i, rd_cnt_s, rd_cnt, sat(i, 15), i);
                failures++;
            end
        end
    endtask

    task automatic test_random();
        logic          w;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            w   = 1'($urandom_range(0, 1));
            d   = DW'($urandom);
            a   = AW'($urandom_range(0, 15));
            // Bias toward reading recently written addresses to exercise write-then-read.
            if (!w && $urandom_range(0, 1) == 1) a = addr;
            cycle(w, d, a);
            rst = 1'b0;
            checks++;
            if (dout !== m_dout || ready !== (m_init == 16) || err !== m_err ||
                wr_cnt !== CW'(sat(m_wr, 65535)) || rd_cnt !== CW'(sat(m_rd, 65535)) ||
                wr_cnt_s !== CWS'(sat(m_wr, 15)) || rd_cnt_s !== CWS'(sat(m_rd, 15))) begin
                $display("FAIL random n=%0d dout=%h/%h ready=%b/%b err=%b/%b wr=%0d/%0d rd=%0d/%0d wr4=%0d/%0d rd4=%0d/%0d",
                         n, dout, m_dout, ready, (m_init == 16), err, m_err, wr_cnt, sat(m_wr, 65535),
                         rd_cnt, sat(m_rd, 65535), wr_cnt_s, sat(m_wr, 15), rd_cnt_s, sat(m_rd, 15));
                failures++;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        wr     = 1'b0;
        din    = '0;
        addr   = '0;
        m_init = 0;
        m_wr   = 0;
        m_rd   = 0;
        m_err  = 1'b0;
        m_dout = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        test_reset();
        test_write_read();
        test_fill_readback();
        test_init_write();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
